chan_scan_mux: RTL and testbench

CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

---
 rtl/chan_scan_mux_pkg.sv | 21 ++
 rtl/chan_scan_mux_scan_cnt.sv | 47 ++++
 rtl/chan_scan_mux.sv | 90 +++++++++
 tb/tb_chan_scan_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/chan_scan_mux_pkg.sv
// Shared types for chan_scan_mux: mode encoding, FSM state and a width helper.
package chan_scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    // Bits needed to index n items; n=1 yields 0, so callers guard that case.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/chan_scan_mux_scan_cnt.sv
// Dwell counter and channel index for scan mode; wrap is a registered pulse
// that is high for the one cycle after idx returns from CH-1 to 0.
module scan_cnt
    import chan_scan_mux_pkg::*;
#(
    parameter int CH    = 4,
    parameter int DWELL = 4,
    localparam int SELW = clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [SELW-1:0] idx,
    output logic            wrap
);

    localparam int CW = (DWELL > 1) ? clog2(DWELL) : 1;

    logic [CW-1:0] cnt;
    logic          last_dwell;
    logic          last_ch;
    logic          advance;

    assign last_dwell = (cnt == CW'(DWELL - 1));
    assign last_ch    = (idx == SELW'(CH - 1));
    assign advance    = en & last_dwell;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            idx  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= advance & last_ch;
            if (en) begin
                if (last_dwell) begin
                    cnt <= '0;
                    idx <= last_ch ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// Channel multiplexer with manual select or timed round-robin scan.
// All outputs registered, latency one cycle from the sampled inputs.
module chan_scan_mux
    import chan_scan_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int DWELL = 4,
    localparam int SELW = clog2(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WIDTH-1:0] din,
    input  logic [SELW-1:0]     sel,
    input  logic                mode,
    input  logic                en,
    output logic [WIDTH-1:0]    out,
    output logic [SELW-1:0]     out_ch,
    output logic                out_valid,
    output logic                wrap
);

    state_t          state;
    state_t          next_state;
    logic [SELW-1:0] idx;
    logic            cnt_wrap;
    logic [SELW-1:0] scan_idx;
    logic [WIDTH-1:0] out_d;
    logic [SELW-1:0] ch_d;
    logic            valid_d;
    logic            wrap_d;

    // Counter is held cleared in MANUAL so the first SCAN cycle already counts toward dwell.
    scan_cnt #(
        .CH    (CH),
        .DWELL (DWELL)
    ) u_scan_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (next_state == MANUAL),
        .en   (en),
        .idx  (idx),
        .wrap (cnt_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= MANUAL;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = (mode == MODE_SCAN) ? SCAN : MANUAL;
    end

    always_comb begin
        scan_idx = (state == MANUAL) ? '0 : idx;
        out_d    = '0;
        if (next_state == SCAN) begin
            ch_d    = scan_idx;
            valid_d = 1'b1;
            wrap_d  = cnt_wrap;
        end else begin
            ch_d    = sel;
            valid_d = (int'(sel) < CH);
            wrap_d  = 1'b0;
        end
        // Select values at or above CH match no channel and leave out_d at zero.
        for (int k = 0; k < CH; k++) begin
            if (ch_d == SELW'(k))
                out_d = din[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            out       <= out_d;
            out_ch    <= ch_d;
            out_valid <= valid_d;
            wrap      <= wrap_d;
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Self-checking bench: reference model feeds a scoreboard queue for the 4-channel
// instance; a 3-channel DWELL=1 instance covers illegal select and per-cycle scan.
module tb_chan_scan_mux;

    localparam int W  = 8;
    localparam int NC = 4;
    localparam int DW = 3;

    typedef struct {
        logic [7:0] out;
        logic [1:0] ch;
        logic       vld;
        logic       wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic [1:0]  sel = '0;
    logic        mode = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  out;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        wrap;

    logic [23:0] d3_din = '0;
    logic [1:0]  d3_sel = '0;
    logic        d3_mode = 1'b0;
    logic        d3_en = 1'b0;
    logic [7:0]  d3_out;
    logic [1:0]  d3_ch;
    logic        d3_vld;
    logic        d3_wrap;

    int errors = 0;
    int checks = 0;
    exp_t sbq[$];
    int m_t = 0;
    logic m_pend = 1'b0;

    logic [7:0] d3_exp_out [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hAA};
    logic [1:0] d3_exp_ch  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic       d3_exp_wr  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    chan_scan_mux #(.WIDTH(W), .CH(NC), .DWELL(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sel       (sel),
        .mode      (mode),
        .en        (en),
        .out       (out),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    chan_scan_mux #(.WIDTH(8), .CH(3), .DWELL(1)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .din       (d3_din),
        .sel       (d3_sel),
        .mode      (d3_mode),
        .en        (d3_en),
        .out       (d3_out),
        .out_ch    (d3_ch),
        .out_valid (d3_vld),
        .wrap      (d3_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the registered result, then compare after the edge.
    task automatic step(input logic r, input logic m, input logic [1:0] s, input logic e);
        exp_t x;
        int   ch;
        rst  = r;
        mode = m;
        sel  = s;
        en   = e;
        if (r) begin
            x = '{out: 8'h0, ch: 2'd0, vld: 1'b0, wrap: 1'b0};
            m_t = 0;
            m_pend = 1'b0;
        end else if (!m) begin
            x = '{out: din[s*W +: W], ch: s, vld: 1'b1, wrap: 1'b0};
            m_t = 0;
            m_pend = 1'b0;
        end else begin
            ch = (m_t / DW) % NC;
            x = '{out: din[ch*W +: W], ch: 2'(ch), vld: 1'b1, wrap: m_pend};
            if (e) begin
                m_t++;
                m_pend = ((m_t % (DW * NC)) == 0);
            end else begin
                m_pend = 1'b0;
            end
        end
        sbq.push_back(x);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk("out", 32'(out), 32'(x.out));
        chk("out_ch", 32'(out_ch), 32'(x.ch));
        chk("out_valid", 32'(out_valid), 32'(x.vld));
        chk("wrap", 32'(wrap), 32'(x.wrap));
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 2'd1, 1'b1);

        // Manual sweep
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 2'(i), 1'b0);

        // Continuous scan through one wrap
        for (int i = 0; i < 14; i++)
            step(1'b0, 1'b1, 2'd0, 1'b1);

        // Freeze on channel 1 and update its data mid-freeze
        step(1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 5)
                din[15:8] = 8'hAA;
            step(1'b0, 1'b1, 2'd0, !(i >= 4 && i <= 6));
        end

        // Reset mid-scan, then restart
        step(1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b1, 2'd0, 1'b1);
        step(1'b1, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 2'd0, 1'b1);

        // Mode toggle scan -> manual -> scan
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 2'd3, 1'b1);
        step(1'b0, 1'b0, 2'd3, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 2'd3, 1'b1);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            din = $urandom;
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end

        // 3-channel instance: illegal select, legal select, then per-cycle scan
        rst     = 1'b0;
        mode    = 1'b0;
        d3_din  = 24'hCCBBAA;
        d3_mode = 1'b0;
        d3_sel  = 2'd3;
        @(posedge clk);
        #1;
        chk("ch3_bad_out", 32'(d3_out), 32'h0);
        chk("ch3_bad_vld", 32'(d3_vld), 32'h0);
        chk("ch3_bad_ch", 32'(d3_ch), 32'h3);
        d3_sel = 2'd2;
        @(posedge clk);
        #1;
        chk("ch3_sel2_out", 32'(d3_out), 32'hCC);
        chk("ch3_sel2_vld", 32'(d3_vld), 32'h1);
        d3_mode = 1'b1;
        d3_en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("ch3_scan_out", 32'(d3_out), 32'(d3_exp_out[i]));
            chk("ch3_scan_ch", 32'(d3_ch), 32'(d3_exp_ch[i]));
            chk("ch3_scan_wrap", 32'(d3_wrap), 32'(d3_exp_wr[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
